hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, meaning the maximum MA wait cycles before abort.
REQ-002 SHALL have ports (reset rst_n, asynchronous, active-low; clock clk):
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- rs1_D, rs2_D  in  5  source registers in ID
- rs1_E, rs2_E, rd_E  in  5  registers in EX
- rd_M, rd_W  in  5  destinations in MA, WB
- reg_write_M, reg_write_W  in  1  destination write enables
- mem_read_E  in  1  load in EX
- pc_src_E  in  1  taken branch/jump resolved in EX
- mem_req_M  in  1  load/store in MA
- mem_ready  in  1  data-memory acknowledge
- stall_F, stall_D, stall_E, stall_M  out  1  hold PC, IF_ID, ID_EX, EX_MA
- flush_D, flush_E, flush_W  out  1  bubble into IF_ID, ID_EX, MA_WB
- fwd_a_E, fwd_b_E  out  2  operand forward selects
- mem_err  out  1  sticky timeout flag
- stall_cycles  out  32  count of cycles with stall_F high

Function
REQ-003 SHALL implement FSM states IDLE and MEM_WAIT.
REQ-004 SHALL transition IDLE->MEM_WAIT when mem_req_M=1 and mem_ready=0.
REQ-005 SHALL transition MEM_WAIT->IDLE when mem_ready=1 or the wait counter equals MEM_TIMEOUT.
REQ-006 SHALL treat mem_req_M=1 with mem_ready=1 in IDLE as a zero-wait access with no stall.
REQ-007 SHALL drive the following when (IDLE and mem_req_M=1 and mem_ready=0) or MEM_WAIT with mem_ready=0:
- stall_F, stall_D, stall_E, stall_M = 1
- flush_W = 1
- all other flushes = 0
REQ-008 SHALL release the stall in the cycle mem_ready=1 is sampled; the MA instruction advances at that edge.
REQ-009 SHALL compute load-use as mem_read_E=1, rd_E!=0, and rd_E equal to rs1_D or rs2_D.
REQ-010 On load-use without a memory stall, SHALL drive stall_F=1, stall_D=1, flush_E=1 for exactly one cycle.
REQ-011 On pc_src_E=1 without a memory stall, SHALL drive flush_D=1 and flush_E=1.
REQ-012 SHALL apply priority: memory stall > pc_src_E > load-use.
- A taken branch coincident with load-use flushes and does not stall.
REQ-013 SHALL defer a branch flush during a memory stall; pc_src_E is re-sampled after release because EX is held.
REQ-014 SHALL set fwd_a_E combinationally:
- 2'b10 if reg_write_M=1, rd_M!=0, rd_M==rs1_E
- else 2'b01 if reg_write_W=1, rd_W!=0, rd_W==rs1_E
- else 2'b00
REQ-015 SHALL derive fwd_b_E identically using rs2_E.
REQ-016 SHALL never forward for register x0.
REQ-017 SHALL keep a 4-bit-minimum wait counter:
- cleared on entry to MEM_WAIT
- incremented each MEM_WAIT cycle with mem_ready=0
REQ-018 On timeout, SHALL:
- set mem_err=1, held until reset
- return to IDLE
- release stalls for one cycle with flush_W=0 so the instruction retires with undefined read data
REQ-019 SHALL increment stall_cycles on every rising edge with stall_F=1, wrapping from 32'hFFFFFFFF to 0.
REQ-020 SHALL make all stall, flush and forward outputs combinational from the current state and inputs, with no added latency.

Reset
REQ-021 SHALL force on rst_n=0, immediately and asynchronously:
- state=IDLE
- wait counter=0
- mem_err=0
- stall_cycles=0
REQ-022 While in reset, SHALL leave combinational outputs reflecting inputs with state=IDLE.
REQ-023 SHALL abandon an in-progress MEM_WAIT on reset assertion, with no stall after release unless re-requested.

Verification
REQ-024 Load-use: rd_E=5, mem_read_E=1, rs1_D=5 -> stall_F=stall_D=flush_E=1 for one cycle; stall_cycles increments by 1.
REQ-025 Forwarding: rd_M=3 with reg_write_M=1, rd_W=3 with reg_write_W=1, rs1_E=3 -> fwd_a_E=2'b10. With rd_M=0 -> fwd_a_E=2'b01. With rs1_E=0 -> 2'b00.
REQ-026 Memory wait: mem_req_M=1 with mem_ready low 3 cycles then high:
- stall_M=1 and flush_W=1 for 3 cycles, 0 on the fourth
- stall_cycles=3
REQ-027 Branch during memory stall: pc_src_E=1 while mem_ready=0 -> flush_D=0. After mem_ready=1 -> flush_D=flush_E=1.
REQ-028 Timeout: mem_ready held 0 with MEM_TIMEOUT=15:
- mem_err rises after 16 stall cycles; state returns IDLE
- mem_err stays 1 until rst_n=0
REQ-029 Reset mid-wait: rst_n pulsed low during MEM_WAIT -> stalls drop immediately; stall_cycles=0; mem_err=0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use, branch and data-memory wait stalls/flushes,
// EX operand forwarding, memory timeout detection and a stall cycle counter.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  rs1_D,
    input  logic [4:0]  rs2_D,
    input  logic [4:0]  rs1_E,
    input  logic [4:0]  rs2_E,
    input  logic [4:0]  rd_E,
    input  logic [4:0]  rd_M,
    input  logic [4:0]  rd_W,
    input  logic        reg_write_M,
    input  logic        reg_write_W,
    input  logic        mem_read_E,
    input  logic        pc_src_E,
    input  logic        mem_req_M,
    input  logic        mem_ready,
    output logic        stall_F,
    output logic        stall_D,
    output logic        stall_E,
    output logic        stall_M,
    output logic        flush_D,
    output logic        flush_E,
    output logic        flush_W,
    output logic [1:0]  fwd_a_E,
    output logic [1:0]  fwd_b_E,
    output logic        mem_err,
    output logic [31:0] stall_cycles
);

    localparam int CW = ($clog2(MEM_TIMEOUT + 1) > 4) ? $clog2(MEM_TIMEOUT + 1) : 4;

    typedef enum logic {
        IDLE     = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          mem_err_q, mem_err_d;
    logic [31:0]   stall_cycles_q, stall_cycles_d;

    logic timeout;
    logic mem_stall;
    logic load_use;
    logic branch_flush;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (reg_write_M && (rd_M != 5'd0) && (rd_M == rs)) begin
            return 2'b10;
        end else if (reg_write_W && (rd_W != 5'd0) && (rd_W == rs)) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    // A real acknowledge in the same cycle as the limit wins over the timeout.
    always_comb begin
        timeout      = (state_q == MEM_WAIT) && !mem_ready && (wait_cnt_q == CW'(MEM_TIMEOUT));
        mem_stall    = !mem_ready && (((state_q == IDLE) && mem_req_M) ||
                                      ((state_q == MEM_WAIT) && !timeout));
        load_use     = mem_read_E && (rd_E != 5'd0) && ((rd_E == rs1_D) || (rd_E == rs2_D));
        branch_flush = pc_src_E && !mem_stall;

        stall_F = mem_stall || (load_use && !pc_src_E);
        stall_D = stall_F;
        stall_E = mem_stall;
        stall_M = mem_stall;
        flush_D = branch_flush;
        flush_E = branch_flush || (load_use && !mem_stall);
        flush_W = mem_stall;

        fwd_a_E = fwd_sel(rs1_E);
        fwd_b_E = fwd_sel(rs2_E);
    end

    always_comb begin
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        mem_err_d      = mem_err_q;
        stall_cycles_d = stall_F ? stall_cycles_q + 32'd1 : stall_cycles_q;
        unique case (state_q)
            IDLE: begin
                if (mem_req_M && !mem_ready) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = '0;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_d = IDLE;
                end else if (timeout) begin
                    state_d   = IDLE;
                    mem_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            wait_cnt_q     <= '0;
            mem_err_q      <= 1'b0;
            stall_cycles_q <= 32'd0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            mem_err_q      <= mem_err_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign mem_err      = mem_err_q;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: combinational vector table plus
// hand-written multi-cycle sequences for load-use, memory wait, timeout and reset.
module tb_hazard_ctrl;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
    logic        reg_write_M, reg_write_W, mem_read_E, pc_src_E, mem_req_M, mem_ready;
    logic        stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W;
    logic [1:0]  fwd_a_E, fwd_b_E;
    logic        mem_err;
    logic [31:0] stall_cycles;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_sc   = 0;

    typedef struct {
        logic [4:0]  rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
        logic        reg_write_M, reg_write_W, mem_read_E, pc_src_E, mem_req_M, mem_ready;
        logic [10:0] exp;
    } vec_t;

    vec_t vecs[16];

    hazard_ctrl #(.MEM_TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E),
        .rd_M(rd_M), .rd_W(rd_W), .reg_write_M(reg_write_M), .reg_write_W(reg_write_W),
        .mem_read_E(mem_read_E), .pc_src_E(pc_src_E), .mem_req_M(mem_req_M),
        .mem_ready(mem_ready),
        .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
        .flush_D(flush_D), .flush_E(flush_E), .flush_W(flush_W),
        .fwd_a_E(fwd_a_E), .fwd_b_E(fwd_b_E), .mem_err(mem_err), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input int a, input int b, input int c, input int d,
                                input int e, input int m, input int w, input int rwm,
                                input int rww, input int mr, input int pc, input int rq,
                                input int rdy, input int ex);
        vec_t v;
        v.rs1_D = 5'(a);  v.rs2_D = 5'(b);  v.rs1_E = 5'(c);  v.rs2_E = 5'(d);
        v.rd_E  = 5'(e);  v.rd_M  = 5'(m);  v.rd_W  = 5'(w);
        v.reg_write_M = 1'(rwm); v.reg_write_W = 1'(rww); v.mem_read_E = 1'(mr);
        v.pc_src_E = 1'(pc); v.mem_req_M = 1'(rq); v.mem_ready = 1'(rdy);
        v.exp = 11'(ex);
        return v;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        rs1_D = 0; rs2_D = 0; rs1_E = 0; rs2_E = 0; rd_E = 0; rd_M = 0; rd_W = 0;
        reg_write_M = 0; reg_write_W = 0; mem_read_E = 0; pc_src_E = 0;
        mem_req_M = 0; mem_ready = 0;
    endtask

    task automatic apply_stimulus(input vec_t v);
        rs1_D = v.rs1_D; rs2_D = v.rs2_D; rs1_E = v.rs1_E; rs2_E = v.rs2_E;
        rd_E = v.rd_E; rd_M = v.rd_M; rd_W = v.rd_W;
        reg_write_M = v.reg_write_M; reg_write_W = v.reg_write_W;
        mem_read_E = v.mem_read_E; pc_src_E = v.pc_src_E;
        mem_req_M = v.mem_req_M; mem_ready = v.mem_ready;
    endtask

    // One rising edge; counts it in the model if stall_F was high before it.
    task automatic step();
        if (stall_F) exp_sc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // {stall_F,stall_D,stall_E,stall_M,flush_D,flush_E,flush_W,fwd_a,fwd_b}
        vecs[0]  = mk(0,0,0,0,0,0,0, 0,0,0,0,0,0, 'b0000000_00_00);
        vecs[1]  = mk(0,0,3,0,0,3,3, 1,1,0,0,0,0, 'b0000000_10_00);
        vecs[2]  = mk(0,0,3,0,0,0,3, 1,1,0,0,0,0, 'b0000000_01_00);
        vecs[3]  = mk(0,0,0,0,0,0,0, 1,1,0,0,0,0, 'b0000000_00_00);
        vecs[4]  = mk(0,0,0,7,0,7,7, 0,1,0,0,0,0, 'b0000000_00_01);
        vecs[5]  = mk(5,0,0,0,5,0,0, 0,0,1,0,0,0, 'b1100010_00_00);
        vecs[6]  = mk(1,5,0,0,5,0,0, 0,0,1,0,0,0, 'b1100010_00_00);
        vecs[7]  = mk(0,0,0,0,0,0,0, 0,0,1,0,0,0, 'b0000000_00_00);
        vecs[8]  = mk(0,0,0,0,0,0,0, 0,0,0,1,0,0, 'b0000110_00_00);
        vecs[9]  = mk(5,0,0,0,5,0,0, 0,0,1,1,0,0, 'b0000110_00_00);
        vecs[10] = mk(0,0,0,0,0,0,0, 0,0,0,0,1,0, 'b1111001_00_00);
        vecs[11] = mk(5,0,0,0,5,0,0, 0,0,1,1,1,0, 'b1111001_00_00);
        vecs[12] = mk(0,0,0,0,0,0,0, 0,0,0,0,1,1, 'b0000000_00_00);
        vecs[13] = mk(5,0,0,0,5,0,0, 0,0,0,0,0,0, 'b0000000_00_00);
        vecs[14] = mk(0,0,3,3,0,3,3, 0,0,0,0,0,0, 'b0000000_00_00);
        vecs[15] = mk(0,0,4,9,0,4,9, 1,1,0,0,0,0, 'b0000000_10_01);

        clear_inputs();
        #2;
        check_output("reset_mem_err", 32'(mem_err), 32'd0);
        check_output("reset_stall_cycles", stall_cycles, 32'd0);

        // Combinational table runs under reset so the FSM stays in IDLE.
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(vecs[i]);
            #1;
            check_output($sformatf("vec%0d", i),
                         32'({stall_F, stall_D, stall_E, stall_M, flush_D, flush_E,
                              flush_W, fwd_a_E, fwd_b_E}), 32'(vecs[i].exp));
        end
        clear_inputs();
        check_output("reset_hold_stall_cycles", stall_cycles, 32'd0);

        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        // Load-use: one stall cycle, then the bubble removes the load from EX.
        rd_E = 5; mem_read_E = 1; rs1_D = 5;
        #1;
        check_output("lu_stall_F", 32'(stall_F), 32'd1);
        check_output("lu_flush_E", 32'(flush_E), 32'd1);
        step();
        clear_inputs();
        #1;
        check_output("lu_release", 32'(stall_F), 32'd0);
        check_output("lu_count", stall_cycles, 32'(exp_sc));
        check_output("lu_count_abs", stall_cycles, 32'd1);

        // Memory wait of three cycles.
        mem_req_M = 1; mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_output($sformatf("mw_stall_M_%0d", i), 32'(stall_M), 32'd1);
            check_output($sformatf("mw_flush_W_%0d", i), 32'(flush_W), 32'd1);
            step();
        end
        mem_ready = 1;
        #1;
        check_output("mw_release_stall_M", 32'(stall_M), 32'd0);
        check_output("mw_release_flush_W", 32'(flush_W), 32'd0);
        step();
        clear_inputs();
        #1;
        check_output("mw_count", stall_cycles, 32'd4);

        // Branch during memory stall is deferred until release.
        mem_req_M = 1; mem_ready = 0; pc_src_E = 1;
        #1;
        check_output("br_idle_flush_D", 32'(flush_D), 32'd0);
        step();
        check_output("br_wait_flush_D", 32'(flush_D), 32'd0);
        check_output("br_wait_flush_E", 32'(flush_E), 32'd0);
        step();
        mem_ready = 1;
        #1;
        check_output("br_rel_flush_D", 32'(flush_D), 32'd1);
        check_output("br_rel_flush_E", 32'(flush_E), 32'd1);
        check_output("br_rel_stall_F", 32'(stall_F), 32'd0);
        step();
        clear_inputs();
        #1;
        check_output("br_count", stall_cycles, 32'(exp_sc));

        // Timeout: 16 stalled cycles, then a released cycle with flush_W low.
        mem_req_M = 1; mem_ready = 0;
        for (int i = 0; i < 16; i++) begin
            #1;
            check_output($sformatf("to_stall_%0d", i), 32'(stall_F), 32'd1);
            step();
        end
        check_output("to_release_stall", 32'(stall_F), 32'd0);
        check_output("to_release_flush_W", 32'(flush_W), 32'd0);
        check_output("to_err_before", 32'(mem_err), 32'd0);
        step();
        mem_req_M = 0;
        #1;
        check_output("to_err_set", 32'(mem_err), 32'd1);
        check_output("to_idle", 32'(stall_F), 32'd0);
        step();
        step();
        check_output("to_err_sticky", 32'(mem_err), 32'd1);
        check_output("to_count", stall_cycles, 32'(exp_sc));

        // Reset asserted in the middle of a wait.
        mem_req_M = 1; mem_ready = 0;
        step();
        mem_req_M = 0;
        #1;
        check_output("rst_wait_stall", 32'(stall_F), 32'd1);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        exp_sc = 0;
        check_output("rst_async_stall", 32'(stall_F), 32'd0);
        check_output("rst_async_count", stall_cycles, 32'd0);
        check_output("rst_async_err", 32'(mem_err), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        step();
        check_output("rst_after_stall", 32'(stall_F), 32'd0);
        check_output("rst_after_count", stall_cycles, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
